exu_ctrl: RTL and testbench

// - Multi-cycle sequencer for the single-issue RV32 core. It steps each instruction through

---
 rtl/exu_ctrl_pkg.sv | 31 +++
 rtl/exu_ctrl_timer.sv | 28 ++
 rtl/exu_ctrl.sv | 83 ++++++++
 tb/tb_exu_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_ctrl_pkg.sv
// Shared types for the RV32 execution sequencer: FSM states and decoded instruction types.
package exu_ctrl_pkg;

  localparam int INST_TYPE_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } inst_type_e;

  // Codes 6 and 7 are unused by the decoder and count as illegal.
  function automatic logic type_legal(input logic [INST_TYPE_WIDTH-1:0] t);
    return t inside {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J};
  endfunction

endpackage

// File: rtl/exu_ctrl_timer.sv
// Bus wait counter shared by instruction fetch and data access.
// expire flags the last permitted waiting cycle (count == TIMEOUT_CYC-1).
module exu_ctrl_timer #(
  parameter int TMR_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [TMR_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == TMR_WIDTH'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/exu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; architectural writes are enabled only in WB.
// Outputs decode the registered state so reset drops every request asynchronously.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int ISA_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TMR_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ifu_req,
  input  logic                       ifu_ready,
  output logic                       inst_en,
  input  logic [INST_TYPE_WIDTH-1:0] inst_type,
  input  logic                       is_load,
  input  logic                       is_store,
  input  logic                       is_ebreak,
  output logic                       lsu_req,
  output logic                       lsu_we,
  input  logic                       lsu_ready,
  input  logic                       pc_w_en_i,
  input  logic                       gpr_w_en_i,
  output logic                       pc_w_en,
  output logic                       gpr_w_en,
  output logic                       halt,
  output logic                       err,
  output logic [ISA_WIDTH-1:0]       instret
);

  state_e state;
  logic   waiting;
  logic   ready;
  logic   expire;

  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign ready   = (state == ST_FETCH) ? ifu_ready : lsu_ready;

  // Held clear outside the wait states, so it restarts on every entry to FETCH or MEM.
  exu_ctrl_timer #(
    .TMR_WIDTH  (TMR_WIDTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!waiting),
    .inc   (waiting && !ready),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      instret <= '0;
    end else begin
      case (state)
        ST_IDLE:   state <= ST_FETCH;
        // A ready on the limit cycle still completes the handshake.
        ST_FETCH:  state <= ifu_ready ? ST_DECODE : (expire ? ST_ERR : ST_FETCH);
        ST_DECODE: state <= type_legal(inst_type) ? ST_EXEC : ST_ERR;
        ST_EXEC:   state <= (is_load || is_store) ? ST_MEM : ST_WB;
        ST_MEM:    state <= lsu_ready ? ST_WB : (expire ? ST_ERR : ST_MEM);
        ST_WB:     state <= is_ebreak ? ST_HALT : ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        ST_ERR:    state <= ST_ERR;
        default:   state <= ST_ERR;
      endcase
      if (state == ST_WB) begin
        instret <= instret + 1'b1;
      end
    end
  end

  assign ifu_req  = (state == ST_FETCH);
  assign inst_en  = ifu_req && ifu_ready;
  assign lsu_req  = (state == ST_MEM);
  assign lsu_we   = lsu_req && is_store;
  assign pc_w_en  = (state == ST_WB) && pc_w_en_i && !is_ebreak;
  assign gpr_w_en = (state == ST_WB) && gpr_w_en_i && !is_ebreak;
  assign halt     = (state == ST_HALT);
  assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_exu_ctrl.sv
// Scoreboard bench for exu_ctrl: a driver pushes expected per-instruction events, a negedge monitor compares.
module tb_exu_ctrl;
  import exu_ctrl_pkg::*;

  localparam int IW  = 4;
  localparam int TMO = 4;

  localparam logic [1:0] K_RET  = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_HALT = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] lat;
    logic [3:0] n_ie;
    logic [7:0] n_lsu;
    logic       we;
    logic       pc;
    logic       gpr;
    logic [3:0] n_en;
    logic [3:0] ir;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req, ifu_ready, inst_en;
  logic [INST_TYPE_WIDTH-1:0] inst_type;
  logic is_load, is_store, is_ebreak;
  logic lsu_req, lsu_we, lsu_ready;
  logic pc_w_en_i, gpr_w_en_i, pc_w_en, gpr_w_en, halt, err;
  logic [IW-1:0] instret;

  int  tests = 0;
  int  fails = 0;
  int  ncyc  = 0;
  int  n_ret = 0;
  ev_t exp_q[$];

  exu_ctrl #(.ISA_WIDTH(IW), .TIMEOUT_CYC(TMO), .TMR_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .inst_en(inst_en),
    .inst_type(inst_type), .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready),
    .pc_w_en_i(pc_w_en_i), .gpr_w_en_i(gpr_w_en_i),
    .pc_w_en(pc_w_en), .gpr_w_en(gpr_w_en), .halt(halt), .err(err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
    if (ncyc > 50000) begin
      tests++;
      fails++;
      $display("FAIL cycle_budget expired after %0d cycles (limit 50000)", ncyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  endtask

  // Scoreboard compare: one observed event against the oldest expected one.
  task automatic check_ev(input ev_t got);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d lat=%0d instret=%0d, none expected", got.kind, got.lat, got.ir);
      return;
    end
    e = exp_q.pop_front();
    if (got != e) begin
      fails++;
      $display("FAIL event got kind=%0d lat=%0d ie=%0d lsu=%0d we=%0d pc=%0d gpr=%0d en=%0d ir=%0d; exp kind=%0d lat=%0d ie=%0d lsu=%0d we=%0d pc=%0d gpr=%0d en=%0d ir=%0d",
               got.kind, got.lat, got.n_ie, got.n_lsu, got.we, got.pc, got.gpr, got.n_en, got.ir,
               e.kind, e.lat, e.n_ie, e.n_lsu, e.we, e.pc, e.gpr, e.n_en, e.ir);
    end
  endtask

  initial begin : monitor
    int   cyc;
    int   s;
    bit   in_inst;
    logic [IW-1:0] p_ir;
    logic p_h, p_e;
    ev_t  acc, h;
    cyc = 0; s = 0; in_inst = 0; p_ir = '0; p_h = 0; p_e = 0; acc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        in_inst = 0; p_ir = '0; p_h = 0; p_e = 0;
      end else begin
        if (instret != p_ir) begin
          acc.kind = K_RET; acc.lat = 8'(cyc - 1 - s); acc.ir = instret;
          check_ev(acc);
          in_inst = 0;
        end
        if (halt && !p_h) begin
          h = '0; h.kind = K_HALT; h.ir = instret;
          check_ev(h);
        end
        if (err && !p_e) begin
          acc.kind = K_ERR; acc.lat = 8'(cyc - s); acc.ir = instret;
          check_ev(acc);
          in_inst = 0;
        end
        if (ifu_req && !in_inst) begin
          in_inst = 1; s = cyc; acc = '0;
        end
        if (in_inst) begin
          acc.n_ie  = acc.n_ie + 4'(inst_en);
          acc.n_lsu = acc.n_lsu + 8'(lsu_req);
          acc.we    = acc.we | lsu_we;
          acc.pc    = acc.pc | pc_w_en;
          acc.gpr   = acc.gpr | gpr_w_en;
          acc.n_en  = acc.n_en + 4'(pc_w_en | gpr_w_en);
        end
        p_ir = instret; p_h = halt; p_e = err;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; ifu_ready = 1'b0; lsu_ready = 1'b0;
    tick();
    tick();
    tests++;
    if ({ifu_req, inst_en, lsu_req, lsu_we, pc_w_en, gpr_w_en, halt, err} !== 8'h00 || instret !== '0) begin
      fails++;
      $display("FAIL reset_outputs got ctl=%b instret=%0d, need all 0", {ifu_req, inst_en, lsu_req, lsu_we, pc_w_en, gpr_w_en, halt, err}, instret);
    end
    n_ret = 0;
    rst = 1'b1;
    tick();
    tests++;
    if (ifu_req !== 1'b1) begin
      fails++;
      $display("FAIL idle_to_fetch ifu_req=%b one cycle after reset release, need 1", ifu_req);
    end
  endtask

  // Reference: expected event(s) from instruction class and handshake delays.
  task automatic do_inst(input logic [2:0] typ, input bit ld, st, eb, pcw, gprw,
                         input int df, dm, output bit term);
    ev_t e, h;
    bit  mem;
    int  k;
    mem = ld || st;
    e = '0;
    e.ir = 4'(n_ret % 16);
    term = 1;
    if (df >= TMO) begin
      e.kind = K_ERR; e.lat = 8'(TMO);
    end else if (!(typ inside {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J})) begin
      e.kind = K_ERR; e.lat = 8'(df + 2); e.n_ie = 4'd1;
    end else if (mem && dm >= TMO) begin
      e.kind = K_ERR; e.lat = 8'(df + 3 + TMO); e.n_ie = 4'd1; e.n_lsu = 8'(TMO); e.we = st;
    end else begin
      n_ret++;
      e.kind  = K_RET;
      e.ir    = 4'(n_ret % 16);
      e.lat   = 8'(df + 3 + (mem ? dm + 1 : 0));
      e.n_ie  = 4'd1;
      e.n_lsu = 8'(mem ? dm + 1 : 0);
      e.we    = mem && st;
      e.pc    = pcw && !eb;
      e.gpr   = gprw && !eb;
      e.n_en  = (e.pc || e.gpr) ? 4'd1 : 4'd0;
      term    = eb;
    end
    exp_q.push_back(e);
    if (e.kind == K_RET && eb) begin
      h = '0; h.kind = K_HALT; h.ir = e.ir;
      exp_q.push_back(h);
    end
    inst_type = typ; is_load = ld; is_store = st; is_ebreak = eb;
    pc_w_en_i = pcw; gpr_w_en_i = gprw;
    while (!ifu_req) begin
      ifu_ready = 1'($urandom_range(0, 1)); lsu_ready = 1'($urandom_range(0, 1));
      tick();
    end
    k = 0;
    while (ifu_req) begin
      ifu_ready = (k == df); lsu_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    k = 0;
    while (!ifu_req && !halt && !err) begin
      if (lsu_req) begin
        lsu_ready = (k == dm);
        k++;
      end else begin
        lsu_ready = 1'($urandom_range(0, 1));
      end
      ifu_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic sticky_check();
    for (int i = 0; i < 4; i++) begin
      ifu_ready = 1'b1; lsu_ready = 1'b1;
      tick();
      tests++;
      if ({ifu_req, inst_en, lsu_req, pc_w_en, gpr_w_en} !== 5'b0 || (halt ^ err) !== 1'b1) begin
        fails++;
        $display("FAIL sticky_stop req/en=%b halt=%b err=%b, need 00000 and exactly one flag", {ifu_req, inst_en, lsu_req, pc_w_en, gpr_w_en}, halt, err);
      end
    end
  endtask

  task automatic end_episode(input bit term);
    if (term) sticky_check();
    ifu_ready = 1'b0; lsu_ready = 1'b0;
    tick();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain %0d expected events never seen, need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : driver
    bit t;
    logic [2:0] typ;
    bit ld, st, eb;
    int df, dm;
    rst = 1'b0; ifu_ready = 1'b0; lsu_ready = 1'b0;
    inst_type = IT_R; is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0;
    pc_w_en_i = 1'b0; gpr_w_en_i = 1'b0;

    // addi, lw with 3-cycle data wait, sw, load+store, branch, late fetch, then ebreak.
    do_reset();
    do_inst(IT_I, 0, 0, 0, 1, 1, 0, 0, t);
    do_inst(IT_I, 1, 0, 0, 1, 1, 0, 3, t);
    do_inst(IT_S, 0, 1, 0, 1, 0, 0, 1, t);
    do_inst(IT_S, 1, 1, 0, 1, 0, 1, 0, t);
    do_inst(IT_B, 0, 0, 0, 1, 0, 2, 0, t);
    do_inst(IT_U, 0, 0, 0, 1, 1, 3, 0, t);
    do_inst(IT_I, 0, 0, 1, 1, 1, 0, 0, t);
    end_episode(t);

    // instret wraps in the 4-bit instance, then a fetch timeout.
    do_reset();
    for (int i = 0; i < 18; i++) do_inst(IT_R, 0, 0, 0, 1, 1, 0, 0, t);
    do_inst(IT_J, 0, 0, 0, 1, 1, TMO, 0, t);
    end_episode(t);

    do_reset();
    do_inst(3'd7, 0, 0, 0, 1, 1, 1, 0, t);
    end_episode(t);

    do_reset();
    do_inst(IT_I, 1, 0, 0, 1, 1, 0, TMO, t);
    end_episode(t);

    // Reset in the middle of a data access.
    do_reset();
    inst_type = IT_S; is_load = 1'b0; is_store = 1'b1; is_ebreak = 1'b0;
    ifu_ready = 1'b1; lsu_ready = 1'b0;
    while (!lsu_req) tick();
    ifu_ready = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (lsu_req !== 1'b0 || lsu_we !== 1'b0) begin
      fails++;
      $display("FAIL async_abort lsu_req=%b lsu_we=%b right after reset, need 0 0", lsu_req, lsu_we);
    end

    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      t = 0;
      for (int i = 0; i < 30 && !t; i++) begin
        typ = ($urandom_range(0, 99) < 3) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        eb  = ($urandom_range(0, 39) == 0);
        ld  = !eb && ($urandom_range(0, 2) == 0);
        st  = !eb && ($urandom_range(0, 2) == 0);
        df  = ($urandom_range(0, 29) == 0) ? TMO : int'($urandom_range(0, 3));
        dm  = ($urandom_range(0, 29) == 0) ? TMO : int'($urandom_range(0, 3));
        do_inst(typ, ld, st, eb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), df, dm, t);
      end
      end_episode(t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
